// File: rtl/alu_test_sequencer.sv
// Steps the board ALU through a ROM of test vectors and tallies pass/fail.
// Optional: define ALU_SEQ_STOP_ON_FAIL_EN to halt on the first mismatch.
module alu_test_sequencer #(
  parameter int NUM_VECTORS   = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int AUTO_DELAY    = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic        auto_mode,
  output logic [7:0]  vec_addr,
  input  logic [53:0] vec_data,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [5:0]  alu_fn,
  input  logic [15:0] alu_out,
  output logic        busy,
  output logic        done,
  output logic [7:0]  cur_index,
  output logic [8:0]  pass_count,
  output logic [8:0]  fail_count,
  output logic        last_fail
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int DW = $clog2(AUTO_DELAY + 1);

  localparam logic [7:0]    LAST  = 8'(NUM_VECTORS - 1);
  localparam logic [SW-1:0] S_END = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] D_END = DW'(AUTO_DELAY - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SETTLE,
    CHECK,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  logic [7:0]    index;
  logic [SW-1:0] settle_cnt;
  logic [DW-1:0] dly_cnt;
  logic [15:0]   expected;
  logic          mismatch;
  logic          last_vec;

  assign vec_addr = index;
  assign busy     = (state != IDLE) && (state != DONE);
  assign done     = (state == DONE);
  assign mismatch = (alu_out != expected);
  assign last_vec = (index == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      index      <= '0;
      settle_cnt <= '0;
      dly_cnt    <= '0;
      expected   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fn     <= '0;
      cur_index  <= '0;
      pass_count <= '0;
      fail_count <= '0;
      last_fail  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            index      <= '0;
            pass_count <= '0;
            fail_count <= '0;
            settle_cnt <= '0;
            dly_cnt    <= '0;
            state      <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          alu_a      <= vec_data[53:38];
          alu_b      <= vec_data[37:22];
          alu_fn     <= vec_data[21:16];
          expected   <= vec_data[15:0];
          cur_index  <= index;
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == S_END)
            state <= CHECK;
          else
            settle_cnt <= settle_cnt + SW'(1);
        end
        CHECK: begin
          last_fail <= mismatch;
          if (mismatch)
            fail_count <= fail_count + 9'd1;
          else
            pass_count <= pass_count + 9'd1;
`ifdef ALU_SEQ_STOP_ON_FAIL_EN
          if (last_vec || mismatch) begin
`else
          if (last_vec) begin
`endif
            state <= DONE;
          end else begin
            dly_cnt <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // mode is re-read each cycle; manual mode freezes the delay count
          if (auto_mode) begin
            if (dly_cnt == D_END) begin
              index <= index + 8'd1;
              state <= FETCH;
            end else begin
              dly_cnt <= dly_cnt + DW'(1);
            end
          end else if (step) begin
            index <= index + 8'd1;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
